// File: rtl/definitions.sv
// rtl/definitions.sv - shared widths and latency of the shift-register/memory core read path
package definitions;

  // Core data and address widths.
  localparam int DATAWIDTH  = 8;
  localparam int ADDRWIDTH  = 8;

  // Cycles from rd_en to DataValid at the core boundary.
  localparam int READ_LAT   = 2;

  // Response FIFO depth; full-rate streaming needs RESP_DEPTH >= READ_LAT + 2.
  localparam int RESP_DEPTH = 4;

endpackage

// File: rtl/resp_fifo.sv
// rtl/resp_fifo.sv - parameterised synchronous response FIFO with occupancy count
module resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               push_data_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               pop_data_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  // A pop request on an empty FIFO is ignored; pushes are never refused since
  // the upstream credit scheme guarantees a free slot.
  assign do_pop = pop_i && (count_q != '0);

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the head data reads as zero afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;

endmodule

// File: rtl/rd_resp_buffer.sv
// rtl/rd_resp_buffer.sv - credit-managed read request/response front end for the memory core
module rd_resp_buffer
  import definitions::*;
#(
  parameter int DEPTH = RESP_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic [ADDRWIDTH-1:0] req_addr,
  output logic                 req_ready,
  output logic                 rd_en,
  output logic [ADDRWIDTH-1:0] addr,
  input  logic [DATAWIDTH-1:0] dataout,
  input  logic                 DataValid,
  output logic                 m_valid,
  output logic [DATAWIDTH-1:0] m_data,
  input  logic                 m_ready,
  output logic                 err_unexp
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                 rd_en_q, rd_en_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]     outstanding_q, outstanding_d;
  logic                 err_q, err_d;

  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 unused_full;
  logic [CNT_W:0]       credit_used;
  logic                 accept;
  logic                 has_outstanding;
  logic                 push;
  logic                 unexpected;

  // Slots already committed: data waiting in the FIFO plus reads still in the
  // core pipeline. One bit wider so DEPTH + DEPTH cannot wrap.
  assign credit_used     = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign req_ready       = (credit_used < (CNT_W + 1)'(DEPTH));
  assign accept          = req_valid && req_ready;
  assign has_outstanding = (outstanding_q != '0);
  assign push            = DataValid && has_outstanding;
  assign unexpected      = DataValid && !has_outstanding;

  // Request register, outstanding-read counter and sticky error next-state.
  always_comb begin
    rd_en_d       = accept;
    addr_d        = addr_q;
    outstanding_d = outstanding_q;
    err_d         = err_q || unexpected;
    if (accept) begin
      addr_d = req_addr;
    end
    case ({accept, push})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Request/credit state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_en_q       <= 1'b0;
      addr_q        <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      rd_en_q       <= rd_en_d;
      addr_q        <= addr_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  resp_fifo #(
    .WIDTH (DATAWIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (dataout),
    .pop_i       (m_ready),
    .pop_data_o  (m_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Credit already bounds occupancy, so the full flag is informational only.
  assign unused_full = fifo_full;

  assign rd_en     = rd_en_q;
  assign addr      = addr_q;
  assign m_valid   = !fifo_empty;
  assign err_unexp = err_q;

endmodule

// File: tb/tb_rd_resp_buffer.sv
// tb/tb_rd_resp_buffer.sv - self-checking bench for rd_resp_buffer with a queue-based reference model
module tb_rd_resp_buffer;
  import definitions::*;

  localparam int DEPTH = RESP_DEPTH;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 req_valid = 1'b0;
  logic [ADDRWIDTH-1:0] req_addr = '0;
  logic                 req_ready;
  logic                 rd_en;
  logic [ADDRWIDTH-1:0] addr;
  logic [DATAWIDTH-1:0] dataout = '0;
  logic                 DataValid = 1'b0;
  logic                 m_valid;
  logic [DATAWIDTH-1:0] m_data;
  logic                 m_ready = 1'b0;
  logic                 err_unexp;

  rd_resp_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rd_en     (rd_en),
    .addr      (addr),
    .dataout   (dataout),
    .DataValid (DataValid),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .err_unexp (err_unexp)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, in-flight reads as a number.
  logic [DATAWIDTH-1:0] mq[$];
  int                   m_out   = 0;
  bit                   m_rd_en = 0;
  logic [ADDRWIDTH-1:0] m_addr  = '0;
  bit                   m_err   = 0;
  bit                   m_acc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_out   = 0;
      m_rd_en = 0;
      m_addr  = '0;
      m_err   = 0;
    end else begin
      m_acc = req_valid && ((mq.size() + m_out) < DEPTH);
      if (m_ready && mq.size() > 0) void'(mq.pop_front());
      if (DataValid) begin
        if (m_out > 0) begin
          mq.push_back(dataout);
          m_out--;
        end else begin
          m_err = 1;
        end
      end
      if (m_acc) begin
        m_out++;
        m_addr = req_addr;
      end
      m_rd_en = m_acc;
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", req_ready, ((mq.size() + m_out) < DEPTH));
      chk("rd_en", rd_en, m_rd_en);
      chk("addr", addr, m_addr);
      chk("m_valid", m_valid, (mq.size() != 0));
      if (mq.size() != 0) chk("m_data", m_data, mq[0]);
      chk("err_unexp", err_unexp, m_err);
      chk("count", dut.fifo_count, mq.size());
      chk("outstanding", dut.outstanding_q, m_out);
    end
  end

  // Core model: returns addr ^ 8'hA0 READ_LAT cycles after rd_en.
  bit                   sv[64];
  logic [DATAWIDTH-1:0] sd[64];
  int                   cyc = 0;
  logic [DATAWIDTH-1:0] popped[$];

  task automatic tick(input bit rv, input logic [ADDRWIDTH-1:0] ra, input bit mr, input bit inj);
    @(negedge clk);
    cyc++;
    if (rd_en) begin
      sv[(cyc + READ_LAT) % 64] = 1'b1;
      sd[(cyc + READ_LAT) % 64] = addr ^ 8'hA0;
    end
    DataValid = sv[cyc % 64] || inj;
    dataout   = inj ? 8'h3C : sd[cyc % 64];
    sv[cyc % 64] = 1'b0;
    req_valid = rv;
    req_addr  = ra;
    m_ready   = mr;
    if (m_valid && mr) popped.push_back(m_data);
  endtask

  task automatic clear_core();
    for (int i = 0; i < 64; i++) sv[i] = 1'b0;
    DataValid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_err"}, err_unexp, 0);
    chk({tag, "_req_ready"}, req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  int acc;
  int idx;
  int t;

  initial begin
    clear_core();
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_reset_outputs("reset");
    chk_en = 1;

    // Single read: addr 5 -> data A5.
    popped.delete();
    tick(1, 8'd5, 0, 0);
    tick(0, 0, 0, 0);
    chk("single_rd_en", rd_en, 1);
    chk("single_addr", addr, 5);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("single_no_bypass", m_valid, 0);
    tick(0, 0, 1, 0);
    chk("single_m_valid", m_valid, 1);
    chk("single_m_data", m_data, 8'hA5);
    tick(0, 0, 0, 0);
    chk("single_drained", m_valid, 0);

    // Credit exhaustion with m_ready held low.
    popped.delete();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1, 8'(i) ^ 8'hA0, 0, 0);
      if (req_ready) acc++;
    end
    chk("credit_accepted", acc, 4);
    repeat (5) tick(0, 0, 0, 0);
    chk("credit_full_ready", req_ready, 0);
    chk("credit_full_count", dut.fifo_count, 4);
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    chk("credit_after_pop", req_ready, 1);
    repeat (5) tick(0, 0, 1, 0);
    chk("credit_pop_n", popped.size(), 4);
    for (int i = 0; i < 4 && i < popped.size(); i++) chk("credit_order", popped[i], i);

    // Accept, DataValid and pop together with count=2, outstanding=1.
    popped.delete();
    tick(1, 8'd10 ^ 8'hA0, 0, 0);
    tick(1, 8'd11 ^ 8'hA0, 0, 0);
    tick(1, 8'd12 ^ 8'hA0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(1, 8'd13 ^ 8'hA0, 1, 0);
    chk("simul_pre_count", dut.fifo_count, 2);
    chk("simul_pre_out", dut.outstanding_q, 1);
    chk("simul_pre_dv", DataValid, 1);
    tick(0, 0, 0, 0);
    chk("simul_post_count", dut.fifo_count, 2);
    chk("simul_post_out", dut.outstanding_q, 1);
    chk("simul_post_head", m_data, 11);
    repeat (6) tick(0, 0, 1, 0);
    chk("simul_pop_n", popped.size(), 4);
    for (int i = 0; i < 4 && i < popped.size(); i++) chk("simul_order", popped[i], 10 + i);

    // Wrap-around: ten values with m_ready toggling.
    popped.delete();
    idx = 0;
    t = 0;
    while (idx < 10 && t < 200) begin
      tick(1, 8'(idx) ^ 8'hA0, (t % 2) == 0, 0);
      if (req_ready) idx++;
      t++;
    end
    chk("wrap_issued", idx, 10);
    while (popped.size() < 10 && t < 400) begin
      tick(0, 0, (t % 2) == 0, 0);
      t++;
    end
    chk("wrap_pop_n", popped.size(), 10);
    for (int i = 0; i < 10 && i < popped.size(); i++) chk("wrap_order", popped[i], i);
    repeat (3) tick(0, 0, 1, 0);
    chk("wrap_no_dup", popped.size(), 10);

    // Unexpected response with nothing outstanding.
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);
    chk("unexp_err", err_unexp, 1);
    chk("unexp_count", dut.fifo_count, 0);
    repeat (3) tick(0, 0, 0, 0);
    chk("unexp_sticky", err_unexp, 1);

    // Reset mid-stream with count=3, outstanding=1.
    for (int i = 0; i < 4; i++) tick(1, 8'(20 + i), 0, 0);
    repeat (3) tick(0, 0, 0, 0);
    chk("mid_pre_count", dut.fifo_count, 3);
    chk("mid_pre_out", dut.outstanding_q, 1);
    #2 reset = 1'b1;
    clear_core();
    #1 check_reset_outputs("mid_async");
    @(negedge clk);
    #2 reset = 1'b0;
    tick(0, 0, 0, 0);
    chk("mid_rel_ready", req_ready, 1);
    chk("mid_rel_valid", m_valid, 0);
    chk("mid_rel_err", err_unexp, 0);
    repeat (4) tick(0, 0, 0, 0);
    chk("mid_quiet", m_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
